// File: rtl/route_table_server.sv
// ----------------------------------------------------------------------------
// route_table_server
//   Responder side of the router routing-table preload interface. After reset
//   it fills internal storage with an XY-mesh routing table, one entry per
//   clock, then raises table_ready. The router reads entries combinationally
//   through table_addr/table_data. A 4-phase req/ack port lets software
//   override single entries at run time. A reload pulse rebuilds the table
//   from the XY rules and discards every override.
//
// Ports
//   clk          in   posedge clock
//   reset        in   synchronous reset, active-low (0 = in reset)
//   table_addr   in   router read address
//   table_data   out  mem[table_addr] while table_ready, else 0 (combinational)
//   table_ready  out  registered; 1 once the table is fully built
//   reload       in   single-cycle pulse; rebuild the table (honoured in READY)
//   cfg_req      in   4-phase config write request
//   cfg_addr     in   config write address, held while cfg_req=1
//   cfg_data     in   config write data, held while cfg_req=1
//   cfg_ack      out  registered 4-phase acknowledge
// ----------------------------------------------------------------------------
module route_table_server #(
  parameter int unsigned DESTINATION_BITS = 7,
  parameter int unsigned CHANNEL_BITS     = 8,
  parameter int unsigned X_BITS           = 3,
  parameter int unsigned MESH_X           = 4,
  parameter int unsigned MESH_Y           = 4,
  parameter int unsigned NODE_X           = 0,
  parameter int unsigned NODE_Y           = 0,
  parameter int unsigned INVALID_CHANNEL  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DESTINATION_BITS-1:0] table_addr,
  output logic [CHANNEL_BITS-1:0]     table_data,
  output logic                        table_ready,
  input  logic                        reload,
  input  logic                        cfg_req,
  input  logic [DESTINATION_BITS-1:0] cfg_addr,
  input  logic [CHANNEL_BITS-1:0]     cfg_data,
  output logic                        cfg_ack
);

  localparam int unsigned DEPTH = 2 ** DESTINATION_BITS;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t                        state_q, state_d;
  logic [DESTINATION_BITS-1:0]   cnt_q, cnt_d;
  logic                          ready_q, ready_d;
  logic                          ack_q, ack_d;

  logic                          we;
  logic [DESTINATION_BITS-1:0]   waddr;
  logic [CHANNEL_BITS-1:0]       wdata;

  logic [CHANNEL_BITS-1:0]       mem_q [DEPTH];

  // XY routing decision for destination address a: resolve x first, then y.
  // Direction codes: 0 local, 1 east, 2 west, 3 north, 4 south.
  function automatic logic [CHANNEL_BITS-1:0] xy_entry(
    input logic [DESTINATION_BITS-1:0] a
  );
    int unsigned dx;
    int unsigned dy;
    logic [2:0]  dir;
    dx = 32'(a[X_BITS-1:0]);
    dy = 32'(a[DESTINATION_BITS-1:X_BITS]);
    if (dx >= MESH_X || dy >= MESH_Y) begin
      return CHANNEL_BITS'(INVALID_CHANNEL);
    end
    if (dx > NODE_X)      dir = 3'd1;
    else if (dx < NODE_X) dir = 3'd2;
    else if (dy < NODE_Y) dir = 3'd3;
    else if (dy > NODE_Y) dir = 3'd4;
    else                  dir = 3'd0;
    return CHANNEL_BITS'(dir);
  endfunction

  // Next-state, write-port and handshake logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    // An outstanding ack only ever follows cfg_req low, in either state.
    ack_d   = ack_q & cfg_req;
    we      = 1'b0;
    waddr   = cnt_q;
    wdata   = xy_entry(cnt_q);

    unique case (state_q)
      S_INIT: begin
        // Fill one entry per cycle; reload and new requests wait.
        we    = 1'b1;
        cnt_d = cnt_q + DESTINATION_BITS'(1);
        if (cnt_q == '1) begin
          state_d = S_READY;
          ready_d = 1'b1;
        end
      end
      S_READY: begin
        if (reload) begin
          // Reload beats a simultaneous new request; that request stays
          // pending and is served once the refill completes.
          state_d = S_INIT;
          cnt_d   = '0;
          ready_d = 1'b0;
        end else if (cfg_req && !ack_q) begin
          we      = 1'b1;
          waddr   = cfg_addr;
          wdata   = cfg_data;
          ack_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  // Storage is not reset; contents only matter once the fill has rewritten
  // every entry. Writes land on the edge, so a same-cycle read sees old data.
  always_ff @(posedge clk) begin
    if (reset && we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign table_data  = ready_q ? mem_q[table_addr] : '0;
  assign table_ready = ready_q;
  assign cfg_ack     = ack_q;

endmodule

// File: tb/tb_route_table_server.sv
// ----------------------------------------------------------------------------
// tb_route_table_server
//   Self-checking bench for route_table_server on a 4x4 mesh with this node
//   at (1,2). A reference table computed from the XY rules with plain
//   arithmetic tracks every override and refill; reads and handshake timing
//   are compared against it under directed and randomized stimulus.
// ----------------------------------------------------------------------------
module tb_route_table_server;

  localparam int unsigned DB    = 7;
  localparam int unsigned CB    = 8;
  localparam int unsigned DEPTH = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] table_addr;
  logic [CB-1:0] table_data;
  logic          table_ready;
  logic          reload;
  logic          cfg_req;
  logic [DB-1:0] cfg_addr;
  logic [CB-1:0] cfg_data;
  logic          cfg_ack;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CB-1:0] model [DEPTH];

  route_table_server #(
    .DESTINATION_BITS(DB),
    .CHANNEL_BITS    (CB),
    .X_BITS          (3),
    .MESH_X          (4),
    .MESH_Y          (4),
    .NODE_X          (1),
    .NODE_Y          (2),
    .INVALID_CHANNEL (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .table_addr (table_addr),
    .table_data (table_data),
    .table_ready(table_ready),
    .reload     (reload),
    .cfg_req    (cfg_req),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_ack    (cfg_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference routing rule, straight from the mesh geometry.
  function automatic logic [CB-1:0] ref_route(input int a);
    int x, y;
    x = a % 8;
    y = a / 8;
    if (x >= 4 || y >= 4) return 8'd0;
    if (x > 1) return 8'd1;
    if (x < 1) return 8'd2;
    if (y < 2) return 8'd3;
    if (y > 2) return 8'd4;
    return 8'd0;
  endfunction

  task automatic model_rebuild();
    for (int a = 0; a < DEPTH; a++) model[a] = ref_route(a);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect table_ready to rise on exactly edge 128 counted from the start of
  // a fill; `done` edges have already elapsed.
  task automatic expect_fill(input string tag, input int done);
    for (int e = done + 1; e <= DEPTH; e++) begin
      tick();
      check(tag, {31'd0, table_ready}, {31'd0, e == DEPTH});
    end
  endtask

  task automatic read_check(input string tag, input int a);
    table_addr = DB'(a);
    #1;
    check(tag, {24'd0, table_data}, {24'd0, model[a]});
  endtask

  // Full 4-phase write in READY with a random request hold time.
  task automatic cfg_write(input int a, input logic [CB-1:0] d);
    int hold;
    table_addr = DB'(a);
    cfg_addr   = DB'(a);
    cfg_data   = d;
    cfg_req    = 1'b1;
    #1;
    check("cfg_same_cycle_old", {24'd0, table_data}, {24'd0, model[a]});
    check("cfg_ack_low_before", {31'd0, cfg_ack}, 32'd0);
    tick();
    model[a] = d;
    check("cfg_ack_rise", {31'd0, cfg_ack}, 32'd1);
    check("cfg_new_value", {24'd0, table_data}, {24'd0, model[a]});
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("cfg_ack_held", {31'd0, cfg_ack}, 32'd1);
    end
    cfg_req = 1'b0;
    tick();
    check("cfg_ack_fall", {31'd0, cfg_ack}, 32'd0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("reload_ready_low", {31'd0, table_ready}, 32'd0);
    model_rebuild();
  endtask

  initial begin
    reset      = 1'b0;
    reload     = 1'b0;
    cfg_req    = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    table_addr = 7'h13;

    // Reset state
    tick();
    tick();
    check("rst_ready", {31'd0, table_ready}, 32'd0);
    check("rst_ack",   {31'd0, cfg_ack},     32'd0);
    check("rst_data",  {24'd0, table_data},  32'd0);

    // Initial fill while watching 0x13
    reset = 1'b1;
    model_rebuild();
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      check("fill_ready", {31'd0, table_ready}, {31'd0, e == DEPTH});
      check("fill_data", {24'd0, table_data}, (e == DEPTH) ? 32'd1 : 32'd0);
    end

    // Directed address sweep including out-of-mesh destinations
    read_check("rd_0x11", 'h11);
    read_check("rd_0x13", 'h13);
    read_check("rd_0x10", 'h10);
    read_check("rd_0x01", 'h01);
    read_check("rd_0x19", 'h19);
    read_check("rd_0x05", 'h05);
    read_check("rd_0x41", 'h41);
    check("rd_0x19_lit", {24'd0, table_data}, 32'd0);  // last read was 0x41
    read_check("rd_0x19b", 'h19);
    check("rd_0x19_is_south", {24'd0, table_data}, 32'd4);

    // Directed config write, then randomized overrides and reads
    cfg_write('h13, 8'h04);
    read_check("rd_after_cfg", 'h13);
    for (int i = 0; i < 12; i++) cfg_write(int'($urandom_range(0, DEPTH - 1)), CB'($urandom));
    for (int i = 0; i < 40; i++) begin
      read_check("rd_rand", int'($urandom_range(0, DEPTH - 1)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Reload discards overrides
    cfg_write('h13, 8'h04);
    pulse_reload();
    table_addr = 7'h13;
    expect_fill("reload_fill", 0);
    read_check("reload_0x13", 'h13);

    // Request raised mid-fill stays pending until READY
    pulse_reload();
    for (int e = 1; e <= 20; e++) tick();
    cfg_addr   = 7'h10;
    cfg_data   = 8'h07;
    cfg_req    = 1'b1;
    table_addr = 7'h10;
    for (int e = 21; e <= DEPTH; e++) begin
      tick();
      check("pend_ack_low", {31'd0, cfg_ack}, 32'd0);
      check("pend_ready", {31'd0, table_ready}, {31'd0, e == DEPTH});
    end
    check("pend_old_value", {24'd0, table_data}, {24'd0, model['h10]});
    tick();
    model['h10] = 8'h07;
    check("pend_ack", {31'd0, cfg_ack}, 32'd1);
    read_check("pend_0x10", 'h10);
    cfg_req = 1'b0;
    tick();
    check("pend_ack_fall", {31'd0, cfg_ack}, 32'd0);

    // Reload together with a new request: reload wins, request served later
    cfg_addr = 7'h22;
    cfg_data = 8'hA5;
    cfg_req  = 1'b1;
    pulse_reload();
    check("rl_req_no_ack", {31'd0, cfg_ack}, 32'd0);
    expect_fill("rl_req_fill", 0);
    check("rl_req_still_pending", {31'd0, cfg_ack}, 32'd0);
    tick();
    model['h22] = 8'hA5;
    check("rl_req_ack", {31'd0, cfg_ack}, 32'd1);
    read_check("rl_req_data", 'h22);

    // Reload while acked: write is lost, ack still follows req low
    pulse_reload();
    check("rl_ack_held", {31'd0, cfg_ack}, 32'd1);
    cfg_req = 1'b0;
    tick();
    check("rl_ack_fall", {31'd0, cfg_ack}, 32'd0);
    expect_fill("rl_ack_fill", 1);
    read_check("rl_ack_0x22", 'h22);

    // Reset mid-fill at count 50 restarts a full fill
    pulse_reload();
    for (int e = 1; e <= 50; e++) tick();
    reset = 1'b0;
    tick();
    check("midfill_rst_ready", {31'd0, table_ready}, 32'd0);
    check("midfill_rst_ack",   {31'd0, cfg_ack},     32'd0);
    reset = 1'b1;
    expect_fill("midfill_refill", 0);

    // Reset mid-handshake clears ack
    cfg_addr = 7'h2A;
    cfg_data = 8'h3C;
    cfg_req  = 1'b1;
    tick();
    check("hs_ack", {31'd0, cfg_ack}, 32'd1);
    reset   = 1'b0;
    cfg_req = 1'b0;
    tick();
    check("hs_rst_ack",   {31'd0, cfg_ack},     32'd0);
    check("hs_rst_ready", {31'd0, table_ready}, 32'd0);
    reset = 1'b1;
    model_rebuild();
    expect_fill("hs_refill", 0);

    // Final full sweep against the reference table
    for (int a = 0; a < DEPTH; a++) read_check("final_sweep", a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
